des_cbc_ctrl: RTL
=================

# des_cbc_ctrl

Sequencer that runs the fixed-key DES core in CBC mode over a stream of 64-bit blocks. It sits between a block source/sink (e.g. the SPI front end) and one des_fixedkey instance. It holds the chaining value (IV), forms the core input, pulses the core start, and waits for done. It returns chained results over valid/ready handshakes, with a watchdog on the core.

## Interface
- TIMEOUT_CYCLES, 64: max cycles from des_start to des_done before an error is flagged (≥ 2).
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- iv_in  in  64  initial chaining value.
- mode_in  in  1  1 encrypt, 0 decrypt; latched with iv_in.
- iv_load  in  1  load IV/mode, clear error and block_count; honoured only in IDLE.
- in_data  in  64  plaintext (encrypt) or ciphertext (decrypt) block.
- in_valid  in  1  source has a block.
- in_ready  out  1  controller accepts a block this cycle.
- out_data  out  64  chained result block.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts out_data.
- des_starttext  out  64  to core starttext.
- des_start  out  1  one-cycle start pulse to core.
- des_encrypt_ndecrypt  out  1  to core; equals latched mode.
- des_finishtext  in  64  core result.
- des_busy  in  1  core busy.
- des_done  in  1  core done pulse.
- error  out  1  sticky watchdog error.
- block_count  out  16  blocks delivered since last iv_load; wraps FFFF→0000.

## Operation
- Registers: iv_reg(64), mode_reg, blk_reg(64, accepted input), state, timer, error, block_count.
- States: IDLE, START, WAIT, OUTPUT.
- IDLE: in_ready = ~iv_load.
  - iv_load=1: iv_reg←iv_in, mode_reg←mode_in, error←0, block_count←0. iv_load wins over a simultaneous in_valid, so no block is accepted that cycle.
  - in_valid&in_ready: blk_reg←in_data. des_starttext←in_data^iv_reg (encrypt) or in_data (decrypt). → START.
- START: if ~des_busy, assert des_start for exactly one cycle, clear timer, → WAIT. Otherwise hold in START.
- WAIT: timer increments each cycle.
  - des_done: encrypt: out_data←des_finishtext, iv_reg←des_finishtext. Decrypt: out_data←des_finishtext^iv_reg, iv_reg←blk_reg. Set out_valid←1, → OUTPUT.
  - No done and timer reaches TIMEOUT_CYCLES−1: error←1, → IDLE. No output; iv_reg and block_count unchanged.
- OUTPUT: out_valid held with out_data stable until out_ready. On the handshake: out_valid←0, block_count+1, → IDLE.
- des_done outside WAIT is ignored.
- iv_load outside IDLE is ignored.
- des_starttext and des_encrypt_ndecrypt are held stable from START until leaving WAIT.
- A new block is never accepted before the previous result is consumed.

## Timing
- Reset values: state IDLE, out_valid 0, out_data 0, des_start 0, des_starttext 0, des_encrypt_ndecrypt 1 (mode_reg=1), iv_reg 0, error 0, block_count 0, timer 0. in_ready is combinational and reads 1 after reset unless iv_load=1.
- Mid-operation reset aborts immediately to reset values. The core shares rst_n.
- Latency with the core idle, core done L cycles after start:
  - Block accepted at cycle 0, des_start at cycle 1.
  - des_done at cycle 1+L, out_valid at cycle 2+L.
  - in_ready returns the cycle after the output handshake.
- Minimum block period: L+3 cycles.
- Watchdog: with no done, error rises at cycle TIMEOUT_CYCLES after des_start. in_ready is high the following cycle.

## Test plan
Bench core model: des_done 17 cycles after des_start, des_finishtext=~des_starttext, busy during the interval.
- Encrypt chain: iv_load IV=0123456789ABCDEF, mode 1. Block 0000000000000000 → des_starttext 0123456789ABCDEF, out FEDCBA9876543210. Block FFFFFFFFFFFFFFFF → starttext 0123456789ABCDEF, out FEDCBA9876543210. block_count=2.
- Decrypt chain: iv_load 0123456789ABCDEF, mode 0. Block FEDCBA9876543210 → out 0000000000000000, iv_reg=FEDCBA9876543210. Block FEDCBA9876543210 → out FFFFFFFFFFFFFFFF. des_encrypt_ndecrypt=0 throughout.
- Backpressure: out_ready low 10 cycles. out_valid/out_data stable, in_ready 0, second in_valid not accepted until after the handshake.
- Timeout: model never asserts done, TIMEOUT_CYCLES=64. error=1 exactly 64 cycles after des_start, out_valid stays 0, block_count unchanged. Next iv_load clears error.
- Collision/reset: iv_load and in_valid together in IDLE → IV loaded, block not accepted. rst_n low during WAIT → all outputs to reset values within the same cycle, no out_valid afterwards.
- Real core integration: encrypt 3 blocks, reload the same IV with mode 0, decrypt the outputs → original plaintexts returned in order.

Source files
------------

// File: rtl/des_cbc_ctrl.sv
// des_cbc_ctrl: CBC-mode sequencer wrapped around one fixed-key DES core.
// The controller accepts a block and forms the core input from it and the
// chaining value. It starts the core, waits for done under a watchdog, and
// returns the chained result over a valid/ready handshake.
module des_cbc_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] iv_in,
   input  logic        mode_in,
   input  logic        iv_load,
   input  logic [63:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [63:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] des_starttext,
   output logic        des_start,
   output logic        des_encrypt_ndecrypt,
   input  logic [63:0] des_finishtext,
   input  logic        des_busy,
   input  logic        des_done,
   output logic        error,
   output logic [15:0] block_count
);

   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_START  = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_OUTPUT = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [63:0]   iv_q, iv_d;
   logic          mode_q, mode_d;
   logic [63:0]   blk_q, blk_d;
   logic [63:0]   stext_q, stext_d;
   logic [TW-1:0] timer_q, timer_d, timer_inc;
   logic          err_q, err_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [63:0]   odata_q, odata_d;
   logic          ovalid_q, ovalid_d;

   assign out_data             = odata_q;
   assign out_valid            = ovalid_q;
   assign des_starttext        = stext_q;
   assign des_encrypt_ndecrypt = mode_q;
   assign error                = err_q;
   assign block_count          = cnt_q;
   assign timer_inc            = timer_q + 1'b1;

   // Next-state logic for the IDLE/START/WAIT/OUTPUT sequencer and its datapath
   always_comb begin
      state_d   = state_q;
      iv_d      = iv_q;
      mode_d    = mode_q;
      blk_d     = blk_q;
      stext_d   = stext_q;
      timer_d   = timer_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      odata_d   = odata_q;
      ovalid_d  = ovalid_q;
      in_ready  = 1'b0;
      des_start = 1'b0;
      case (state_q)
         S_IDLE: begin
            // iv_load takes the cycle, so a coincident block is not taken
            in_ready = ~iv_load;
            if (iv_load) begin
               iv_d   = iv_in;
               mode_d = mode_in;
               err_d  = 1'b0;
               cnt_d  = 16'd0;
            end else if (in_valid) begin
               blk_d   = in_data;
               stext_d = mode_q ? (in_data ^ iv_q) : in_data;
               state_d = S_START;
            end
         end
         S_START: begin
            // des_start is combinational so it fires the cycle after acceptance
            if (!des_busy) begin
               des_start = 1'b1;
               timer_d   = '0;
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            timer_d = timer_inc;
            if (des_done) begin
               if (mode_q) begin
                  odata_d = des_finishtext;
                  iv_d    = des_finishtext;
               end else begin
                  odata_d = des_finishtext ^ iv_q;
                  iv_d    = blk_q;
               end
               ovalid_d = 1'b1;
               state_d  = S_OUTPUT;
            end else if (timer_inc == TMO_LAST) begin
               // Time out so that error shows TIMEOUT_CYCLES after des_start.
               // The chaining value and the count are left untouched.
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_OUTPUT: begin
            if (out_ready) begin
               ovalid_d = 1'b0;
               cnt_d    = cnt_q + 16'd1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         iv_q     <= '0;
         mode_q   <= 1'b1;
         blk_q    <= '0;
         stext_q  <= '0;
         timer_q  <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         odata_q  <= '0;
         ovalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         iv_q     <= iv_d;
         mode_q   <= mode_d;
         blk_q    <= blk_d;
         stext_q  <= stext_d;
         timer_q  <= timer_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         odata_q  <= odata_d;
         ovalid_q <= ovalid_d;
      end
   end

endmodule
